// File: rtl/axis_avg2_decim_pkg.sv
// Shared definitions for the decimate-by-2 averaging stage: pairing state
// encoding and default rail widths.
package axis_avg2_decim_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TDATA_W = 2 * DEF_WIDTH;

  // S_FIRST: no sample held; S_SECOND: first sample of a pair is held.
  typedef enum logic {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } state_t;

endpackage

// File: rtl/axis_avg2_decim_add2.sv
// Exact average of two signed rails, truncated toward zero. The sum is kept
// at WIDTH+1 bits, so the result can never overflow.
module add2_and_round #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] avg_o
);

  logic [WIDTH:0] sum;

  assign sum = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};

  // An arithmetic shift floors; bump negative odd sums back toward zero.
  assign avg_o = sum[WIDTH:1] + {{(WIDTH-1){1'b0}}, sum[WIDTH] & sum[0]};

endmodule

// File: rtl/axis_avg2_decim.sv
// Streaming decimate-by-2: pairs consecutive beats and emits their per-rail
// average, with bypass and odd-tail passthrough, through a one-deep output reg.
module axis_avg2_decim
  import axis_avg2_decim_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               bypass,
  input  logic [2*WIDTH-1:0] i_tdata,
  input  logic               i_tlast,
  input  logic               i_tvalid,
  output logic               i_tready,
  output logic [2*WIDTH-1:0] o_tdata,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               o_tready,
  output state_t             dbg_state
);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] hold_q, hold_d;
  logic [2*WIDTH-1:0] data_q, data_d;
  logic               last_q, last_d;
  logic               valid_q, valid_d;
  logic               accept;
  logic               load;
  logic [WIDTH-1:0]   avg_i, avg_q;

  // Handshake: a beat moves on a rising edge where valid & ready are both 1.
  // Input ready depends only on the output register and o_tready, never on
  // input data, so a new beat can be loaded in the same cycle one is taken.
  assign i_tready  = ~valid_q | o_tready;
  assign accept    = i_tvalid & i_tready;
  assign o_tdata   = data_q;
  assign o_tlast   = last_q;
  assign o_tvalid  = valid_q;
  assign dbg_state = state_q;

  add2_and_round #(.WIDTH(WIDTH)) u_avg_i (
    .a_i   (hold_q[2*WIDTH-1:WIDTH]),
    .b_i   (i_tdata[2*WIDTH-1:WIDTH]),
    .avg_o (avg_i)
  );

  add2_and_round #(.WIDTH(WIDTH)) u_avg_q (
    .a_i   (hold_q[WIDTH-1:0]),
    .b_i   (i_tdata[WIDTH-1:0]),
    .avg_o (avg_q)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    data_d  = data_q;
    last_d  = last_q;
    load    = 1'b0;
    if (accept) begin
      if (state_q == S_FIRST) begin
        // Bypass and a lone tail beat both pass through unaveraged.
        if (bypass || i_tlast) begin
          load   = 1'b1;
          data_d = i_tdata;
          last_d = i_tlast;
        end else begin
          hold_d  = i_tdata;
          state_d = S_SECOND;
        end
      end else begin
        load    = 1'b1;
        data_d  = {avg_i, avg_q};
        last_d  = i_tlast;
        state_d = S_FIRST;
      end
    end
    if (load) begin
      valid_d = 1'b1;
    end else if (o_tready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= S_FIRST;
      hold_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

endmodule
